// File: rtl/pkt_frame_fsm_if.sv
// Valid/ready stream bundle for pkt_frame_fsm: input beat channel plus framed output channel.
// master drives beats in and takes beats out; slave is the framer.
interface pkt_frame_fsm_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic              in_head;
  logic              in_tail;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic              out_ready;
  logic              out_sop;
  logic              out_eop;
  logic              out_abort;
  logic [DATA_W-1:0] out_data;

  modport master (
    output in_valid, in_head, in_tail, in_data, out_ready,
    input  in_ready, out_valid, out_sop, out_eop, out_abort, out_data
  );

  modport slave (
    input  in_valid, in_head, in_tail, in_data, out_ready,
    output in_ready, out_valid, out_sop, out_eop, out_abort, out_data
  );
endinterface

// File: rtl/pkt_frame_fsm.sv
// Packet-framing FSM: checks head/data/tail framing and length, forwards good beats through a
// one-deep output register with SOP/EOP/abort. Optional counters under PKT_FRAME_STATS_EN.
module pkt_frame_fsm #(
  parameter int DATA_W  = 8,
  parameter int LEN_W   = 4,
  parameter int MAX_LEN = 8
) (
  input  logic             clk,
  input  logic             reset,
  pkt_frame_fsm_if.slave   bus,
  output logic [2:0]       state,
  output logic [LEN_W-1:0] pkt_len,
  output logic [1:0]       err_code,
  input  logic             err_clr
`ifdef PKT_FRAME_STATS_EN
  ,
  output logic [15:0]      pkt_cnt,
  output logic [15:0]      drop_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HEAD = 3'd1,
    S_DATA = 3'd2,
    S_TAIL = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  localparam logic [LEN_W-1:0] LAST_CNT = LEN_W'(MAX_LEN - 1);

  state_t           cur_state, nxt_state;
  logic [LEN_W-1:0] count_q, count_d;
  logic [LEN_W-1:0] len_d;
  logic [1:0]       err_d;
  logic [1:0]       new_err;
  logic             accept;
  logic             fwd, f_sop, f_eop, f_abort;
  logic             drop, good;

  assign bus.in_ready = !bus.out_valid | bus.out_ready;
  assign accept       = bus.in_valid & bus.in_ready;
  assign state        = cur_state;

  always_comb begin
    nxt_state = cur_state;
    count_d   = count_q;
    len_d     = pkt_len;
    new_err   = 2'd0;
    fwd       = 1'b0;
    f_sop     = 1'b0;
    f_eop     = 1'b0;
    f_abort   = 1'b0;
    drop      = 1'b0;
    good      = 1'b0;
    case (cur_state)
      S_IDLE, S_TAIL, S_ERR: begin
        if (accept) begin
          if (bus.in_head) begin
            fwd   = 1'b1;
            f_sop = 1'b1;
            if (bus.in_tail) begin
              nxt_state = S_TAIL;
              f_eop     = 1'b1;
              len_d     = LEN_W'(1);
              count_d   = '0;
              good      = 1'b1;
            end else begin
              nxt_state = S_HEAD;
              count_d   = LEN_W'(1);
            end
          end else begin
            drop = 1'b1;
            // ERR swallows stray beats silently until a tail closes the broken packet
            if (cur_state == S_ERR) begin
              if (bus.in_tail) nxt_state = S_IDLE;
            end else begin
              nxt_state = S_IDLE;
              new_err   = 2'd1;
            end
          end
        end else if (cur_state == S_TAIL) begin
          nxt_state = S_IDLE;
        end
      end
      S_HEAD, S_DATA: begin
        if (accept) begin
          fwd = 1'b1;
          if (bus.in_head) begin
            nxt_state = S_ERR;
            f_eop     = 1'b1;
            f_abort   = 1'b1;
            new_err   = 2'd2;
            count_d   = '0;
          end else if (bus.in_tail) begin
            nxt_state = S_TAIL;
            f_eop     = 1'b1;
            len_d     = count_q + LEN_W'(1);
            count_d   = '0;
            good      = 1'b1;
          end else if (count_q == LAST_CNT) begin
            nxt_state = S_ERR;
            f_eop     = 1'b1;
            f_abort   = 1'b1;
            new_err   = 2'd3;
            count_d   = '0;
          end else begin
            nxt_state = S_DATA;
            count_d   = count_q + LEN_W'(1);
          end
        end
      end
      default: nxt_state = S_IDLE;
    endcase

    // first error is sticky, but a clear in the same cycle lets the new error in
    if (new_err != 2'd0 && (err_code == 2'd0 || err_clr)) err_d = new_err;
    else if (err_clr)                                      err_d = 2'd0;
    else                                                   err_d = err_code;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_state     <= S_IDLE;
      count_q       <= '0;
      pkt_len       <= '0;
      err_code      <= 2'd0;
      bus.out_valid <= 1'b0;
      bus.out_sop   <= 1'b0;
      bus.out_eop   <= 1'b0;
      bus.out_abort <= 1'b0;
      bus.out_data  <= '0;
    end else begin
      cur_state <= nxt_state;
      count_q   <= count_d;
      pkt_len   <= len_d;
      err_code  <= err_d;
      if (fwd) begin
        bus.out_valid <= 1'b1;
        bus.out_sop   <= f_sop;
        bus.out_eop   <= f_eop;
        bus.out_abort <= f_abort;
        bus.out_data  <= bus.in_data;
      end else if (bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
    end
  end

`ifdef PKT_FRAME_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pkt_cnt  <= '0;
      drop_cnt <= '0;
    end else if (err_clr) begin
      pkt_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      if (good && pkt_cnt != 16'hFFFF)                          pkt_cnt  <= pkt_cnt + 16'd1;
      if ((drop || (fwd && f_abort)) && drop_cnt != 16'hFFFF)   drop_cnt <= drop_cnt + 16'd1;
    end
  end
`endif

endmodule
